wam_scan: RTL and testbench

WAM_SCAN -- requirements
Module: wam_scan

---
 rtl/wam_pkg.sv | 46 ++++
 rtl/wam_seg7.sv | 15 +
 rtl/wam_scan.sv | 225 ++++++++++++++++++++++
 tb/tb_wam_scan.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// wam_pkg -- shared constants for the wam_scan seven-segment scanner.
//
// Contents:
//   CODE_BLANK   digit code that lights no segment
//   CODE_HIGH_O  digit code for the raised "o" glyph
//   CODE_ZERO    digit code that leading-zero blanking looks for
//   SEG_OFF      active-low segment pattern with every segment dark
//   SEG7_TAB     glyph table indexed by the 4-bit digit code; bit 6 is
//                segment a, bit 0 is segment g, all active-low
//   ld_state_t   states of the load handshake FSM in wam_scan
package wam_pkg;

   localparam logic [3:0] CODE_BLANK  = 4'hA;
   localparam logic [3:0] CODE_HIGH_O = 4'hB;
   localparam logic [3:0] CODE_ZERO   = 4'h0;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Entry order is 15 down to 0 so that SEG7_TAB[code] selects the glyph.
   localparam logic [15:0][6:0] SEG7_TAB = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // D
      7'b0110001,  // C
      7'b0011100,  // B  high o
      7'b1111111,  // A  blank
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   // LD_IDLE: ld_ready high, nothing waiting.
   // LD_PEND: a load sits in the pending register until the next frame boundary.
   typedef enum logic {
      LD_IDLE = 1'b0,
      LD_PEND = 1'b1
   } ld_state_t;

endpackage

// File: rtl/wam_seg7.sv
// wam_seg7 -- combinational digit-code to seven-segment decoder.
//
// Ports:
//   code  4-bit digit code (0-9 decimal, A blank, B high o, C-F letters)
//   a2g   active-low segments, a2g[6] = a ... a2g[0] = g
module wam_seg7
   import wam_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] a2g
);

   assign a2g = SEG7_TAB[code];

endmodule

// File: rtl/wam_scan.sv
// wam_scan -- multiplexed seven-segment display scanner with a load handshake.
//
// The scanner steps through NDIG digits, one digit slot every DIV clocks.
// Displayed codes come from a shadow register that only changes at a frame
// boundary, so a frame never shows a mix of old and new digits. New data is
// taken through a valid/ready handshake into a pending register first.
//
// Handshake: a load is accepted on a rising edge where ld_valid && ld_ready.
// ld_ready is low from the cycle after an accept until the cycle after the
// frame boundary that moves pending into shadow. ld_data may change freely
// while ld_ready is low.
//
// Build option: define WAM_SCAN_BLINK_EN to enable per-digit blinking driven
// by a frame counter; without it the blink port is ignored.
//
// Parameters:
//   NDIG        digit count, 2..8
//   DIV         clocks per digit slot, >= 1
//   BLINK_LOG2  blink phase toggles every 2^BLINK_LOG2 frames
// Ports:
//   clk_16      clock, rising edge
//   rst         asynchronous active-high reset
//   ld_data     digit codes, digit i in [4i+3:4i]
//   ld_valid    load request
//   ld_ready    load can be accepted
//   lzb         leading-zero blanking enable
//   blink       per-digit blink mask
//   an          active-low one-hot digit select (registered)
//   a2g         active-low segments a..g (registered)
//   frame_done  one-cycle pulse after each completed frame
module wam_scan
   import wam_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int DIV        = 1,
   parameter int BLINK_LOG2 = 4
) (
   input  logic              clk_16,
   input  logic              rst,
   input  logic [4*NDIG-1:0] ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              lzb,
   input  logic [NDIG-1:0]   blink,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        a2g,
   output logic              frame_done
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [4*NDIG-1:0] ALL_BLANK = {NDIG{CODE_BLANK}};

   // ------------------------------------------------------------------
   // Slot timing
   // ------------------------------------------------------------------
   logic [PW-1:0] pre;
   logic [IW-1:0] idx;
   logic          tick;
   logic          boundary;

   assign tick     = (pre == PRE_LAST);
   assign boundary = tick && (idx == IDX_LAST);

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (tick) begin
         idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Load handshake FSM
   // ------------------------------------------------------------------
   ld_state_t         ld_state;
   ld_state_t         ld_state_nxt;
   logic              pend_load;
   logic              shadow_load;
   logic [4*NDIG-1:0] pending;
   logic [4*NDIG-1:0] shadow;

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         ld_state <= LD_IDLE;
      end else begin
         ld_state <= ld_state_nxt;
      end
   end

   // An accept in the boundary cycle lands in LD_PEND and therefore waits for
   // the following boundary: shadow_load only fires from LD_PEND.
   always_comb begin
      ld_state_nxt = ld_state;
      pend_load    = 1'b0;
      shadow_load  = 1'b0;
      case (ld_state)
         LD_IDLE: begin
            if (ld_valid) begin
               pend_load    = 1'b1;
               ld_state_nxt = LD_PEND;
            end
         end
         LD_PEND: begin
            if (boundary) begin
               shadow_load  = 1'b1;
               ld_state_nxt = LD_IDLE;
            end
         end
         default: ld_state_nxt = LD_IDLE;
      endcase
   end

   assign ld_ready = (ld_state == LD_IDLE);

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         pending <= ALL_BLANK;
      end else if (pend_load) begin
         pending <= ld_data;
      end
   end

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         shadow <= ALL_BLANK;
      end else if (shadow_load) begin
         shadow <= pending;
      end
   end

   // ------------------------------------------------------------------
   // Blanking
   // ------------------------------------------------------------------
   // A digit is a leading zero only if it is zero and every digit above it
   // was also blanked as a zero; an A (blank) code breaks the chain.
   logic [NDIG-1:0] lz_blank;
   logic            lz_run;

   always_comb begin
      lz_blank = '0;
      lz_run   = lzb;
      for (int i = NDIG - 1; i >= 1; i--) begin
         lz_run      = lz_run && (shadow[4*i +: 4] == CODE_ZERO);
         lz_blank[i] = lz_run;
      end
   end

   logic [NDIG-1:0] blink_off;

`ifdef WAM_SCAN_BLINK_EN
   // The MSB of this counter is the blink phase.
   logic [BLINK_LOG2:0] frame_cnt;

   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (boundary) begin
         frame_cnt <= frame_cnt + (BLINK_LOG2 + 1)'(1);
      end
   end

   assign blink_off = blink & {NDIG{frame_cnt[BLINK_LOG2]}};
`else
   logic unused_blink;

   assign unused_blink = ^blink;
   assign blink_off    = '0;
`endif

   // ------------------------------------------------------------------
   // Digit select and decode
   // ------------------------------------------------------------------
   logic [3:0]      cur_code;
   logic            cur_off;
   logic [3:0]      disp_code;
   logic [6:0]      seg_nxt;
   logic [NDIG-1:0] an_nxt;

   always_comb begin
      cur_code = CODE_BLANK;
      cur_off  = 1'b0;
      an_nxt   = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) begin
            cur_code  = shadow[4*i +: 4];
            cur_off   = lz_blank[i] | blink_off[i];
            an_nxt[i] = 1'b0;
         end
      end
   end

   assign disp_code = cur_off ? CODE_BLANK : cur_code;

   wam_seg7 u_seg7 (
      .code (disp_code),
      .a2g  (seg_nxt)
   );

   // Outputs trail idx by one cycle; frame_done follows the boundary tick.
   always_ff @(posedge clk_16 or posedge rst) begin
      if (rst) begin
         an         <= '1;
         a2g        <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         an         <= an_nxt;
         a2g        <= seg_nxt;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_wam_scan.sv
// tb_wam_scan -- self-checking bench for wam_scan (NDIG=4, DIV=4, BLINK_LOG2=1).
//
// The driver pushes the expected {an, a2g} of every digit slot it cares about
// into exp_q at a frame boundary; a monitor pops one entry each time a new
// digit slot appears on an and compares it. The monitor also checks slot
// length and the spacing of frame_done pulses.
module tb_wam_scan;

   localparam int NDIG = 4;
   localparam int DIV  = 4;
   localparam int FRAME_CYC = NDIG * DIV;

   localparam logic [6:0] G0 = 7'b0000001;
   localparam logic [6:0] G1 = 7'b1001111;
   localparam logic [6:0] G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110;
   localparam logic [6:0] G5 = 7'b0100100;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] GB = 7'b1111111;

   logic              clk_16;
   logic              rst;
   logic [4*NDIG-1:0] ld_data;
   logic              ld_valid;
   logic              ld_ready;
   logic              lzb;
   logic [NDIG-1:0]   blink;
   logic [NDIG-1:0]   an;
   logic [6:0]        a2g;
   logic              frame_done;

   int total;
   int bad;

   logic [10:0] exp_q[$];

   wam_scan #(
      .NDIG       (NDIG),
      .DIV        (DIV),
      .BLINK_LOG2 (1)
   ) dut (
      .clk_16     (clk_16),
      .rst        (rst),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .lzb        (lzb),
      .blink      (blink),
      .an         (an),
      .a2g        (a2g),
      .frame_done (frame_done)
   );

   // ------------------------------------------------------------------
   // Clock and watchdog
   // ------------------------------------------------------------------
   initial clk_16 = 1'b0;
   always #5 clk_16 = ~clk_16;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] gl(input logic [6:0] g3, input logic [6:0] g2,
                                      input logic [6:0] g1, input logic [6:0] g0);
      return {g3, g2, g1, g0};
   endfunction

   task automatic push_frame(input logic [27:0] g);
      exp_q.push_back({4'b1110, g[6:0]});
      exp_q.push_back({4'b1101, g[13:7]});
      exp_q.push_back({4'b1011, g[20:14]});
      exp_q.push_back({4'b0111, g[27:21]});
   endtask

   // Returns at the falling edge where frame_done is high.
   task automatic sync_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk_16);
         n++;
      end while (!frame_done && n < 4 * FRAME_CYC);
      if (!frame_done) check("sync_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 10 * FRAME_CYC) begin
         @(negedge clk_16);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // Issue one load from the current falling edge; ld_ready must be high.
   task automatic load(input logic [15:0] data);
      check("ld_ready_idle", ld_ready, 1'b1);
      ld_data  = data;
      ld_valid = 1'b1;
      @(posedge clk_16);
      #1;
      ld_valid = 1'b0;
      check("ld_ready_drop", ld_ready, 1'b0);
   endtask

   // From a sync point: the next frame still shows old, the one after shows new.
   task automatic step(input logic [27:0] old_g, input logic [27:0] new_g, input logic [15:0] data);
      push_frame(old_g);
      push_frame(new_g);
      load(data);
      drain();
   endtask

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   initial begin
      logic [NDIG-1:0] prev_an;
      logic [10:0]     e;
      int              run;
      int              fd_gap;
      bit              last_checked;
      bit              fd_seen;
      prev_an      = '1;
      run          = 0;
      fd_gap       = 0;
      last_checked = 0;
      fd_seen      = 0;
      forever begin
         @(negedge clk_16);
         if (rst) begin
            prev_an      = '1;
            run          = 0;
            last_checked = 0;
            fd_seen      = 0;
         end else begin
            if (an != prev_an) begin
               if (last_checked) check("slot_len", run, DIV);
               last_checked = 0;
               if (an != 4'b1111 && exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("slot", {an, a2g}, e);
                  last_checked = 1;
               end
               run     = 1;
               prev_an = an;
            end else begin
               run++;
            end
            if (frame_done) begin
               if (fd_seen) check("frame_gap", fd_gap, FRAME_CYC);
               fd_seen = 1;
               fd_gap  = 1;
            end else begin
               fd_gap++;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------
   initial begin
      logic [6:0] d0;
      int         n;
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      ld_data  = '0;
      ld_valid = 1'b0;
      lzb      = 1'b0;
      blink    = '0;

      repeat (3) @(negedge clk_16);
      check("rst_an", an, 4'b1111);
      check("rst_a2g", a2g, 7'b1111111);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_ld_ready", ld_ready, 1'b1);
      rst = 1'b0;

      // Basic scan of 1230
      sync_frame();
      step(gl(GB, GB, GB, GB), gl(G1, G2, G3, G0), 16'h1230);

      // Leading-zero blanking
      sync_frame();
      lzb = 1'b1;
      step(gl(G1, G2, G3, G0), gl(GB, GB, G5, G0), 16'h0050);
      sync_frame();
      step(gl(GB, GB, G5, G0), gl(GB, GB, GB, G0), 16'h0000);
      sync_frame();
      step(gl(GB, GB, GB, G0), gl(GB, GB, G0, G5), 16'h0A05);
      sync_frame();
      lzb = 1'b0;
      step(gl(G0, GB, G0, G5), gl(G1, G0, G3, G0), 16'h1030);

      // ld_valid held across back-to-back loads
      sync_frame();
      push_frame(gl(G1, G0, G3, G0));
      push_frame(gl(G1, G1, G1, G1));
      push_frame(gl(G2, G2, G2, G2));
      check("b2b_ready_first", ld_ready, 1'b1);
      ld_data  = 16'h1111;
      ld_valid = 1'b1;
      @(posedge clk_16);
      #1;
      ld_data = 16'h2222;
      check("b2b_ready_drop", ld_ready, 1'b0);
      n = 0;
      while (!ld_ready && n < 4 * FRAME_CYC) begin
         @(posedge clk_16);
         #1;
         n++;
      end
      check("b2b_ready_back", ld_ready, 1'b1);
      check("b2b_ready_after_bnd", frame_done, 1'b1);
      @(posedge clk_16);
      #1;
      ld_valid = 1'b0;
      check("b2b_second_accept", ld_ready, 1'b0);
      drain();

      // Accept on the frame-boundary cycle waits a whole extra frame
      sync_frame();
      push_frame(gl(G2, G2, G2, G2));
      push_frame(gl(G2, G2, G2, G2));
      push_frame(gl(G3, G5, G3, G5));
      repeat (FRAME_CYC - 1) @(negedge clk_16);
      check("bnd_ready", ld_ready, 1'b1);
      ld_data  = 16'h3535;
      ld_valid = 1'b1;
      @(posedge clk_16);
      #1;
      ld_valid = 1'b0;
      check("bnd_on_boundary", frame_done, 1'b1);
      check("bnd_ready_drop", ld_ready, 1'b0);
      drain();

      // Reset mid-slot at idx=2 with a load pending
      sync_frame();
      load(16'h1111);
      n = 0;
      while (an != 4'b1011 && n < 4 * FRAME_CYC) begin
         @(negedge clk_16);
         n++;
      end
      check("mid_slot_reached", an, 4'b1011);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_an", an, 4'b1111);
      check("mid_rst_a2g", a2g, 7'b1111111);
      check("mid_rst_ld_ready", ld_ready, 1'b1);
      check("mid_rst_frame_done", frame_done, 1'b0);
      repeat (3) @(negedge clk_16);
      check("mid_rst_hold_an", an, 4'b1111);

      // Blink on digit 0 after a fresh reset: frame 0 blank, then 1238.
      blink = 4'b0001;
      push_frame(gl(GB, GB, GB, GB));
      for (int f = 1; f < 8; f++) begin
`ifdef WAM_SCAN_BLINK_EN
         d0 = (f % 4 >= 2) ? GB : G8;
`else
         d0 = G8;
`endif
         push_frame(gl(G1, G2, G3, d0));
      end
      rst = 1'b0;
      load(16'h1238);
      drain();

      repeat (2 * FRAME_CYC) @(negedge clk_16);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
